sensor_poll_arbiter: RTL and testbench
======================================

Name: sensor_poll_arbiter

Overview:
Parametrised successor to the single-byte sensor request arbiter. Accepts a sensor request from the processor custom-instruction interface and sends the sensor address as one UART byte. It then collects a multi-byte response (DATA_BYTES data bytes plus one XOR checksum byte) under a cycle-accurate timeout and retries on timeout or checksum failure. It returns data and status to the processor with a one-cycle done pulse. It sits between the processor instruction slot and the existing uart_tx/uart_rx byte engines.

Parameters:
ADDR_W, 8, width of sensor address taken from dataA[ADDR_W-1:0]; legal range 1..8
DATA_BYTES, 2, data bytes per response, 1..3
TIMEOUT_CYCLES, 500000000, clock cycles allowed per attempt (10 s at 50 MHz)
MAX_RETRIES, 2, extra attempts after the first, 0..15
SEED, 8'h37, checksum seed

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  request strobe, sampled only in IDLE
dataA  in  32  request word; [ADDR_W-1:0] = sensor address, rest ignored
tx_byte  out  8  byte presented to uart_tx; address zero-extended
tx_dv  out  1  one-cycle send strobe to uart_tx
tx_done  in  1  uart_tx completion pulse
rx_byte  in  8  byte from uart_rx
rx_dv  in  1  uart_rx byte-valid pulse
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
result  out  32  [23:0] data, [27:24] retries used, [29:28] status, [31:30] zero

Behaviour:
- Reset (synchronous, active-high, clock clock):
  - state goes to IDLE.
  - tx_dv=0, done=0, busy=0, result=0, tx_byte=0.
  - Retry count, byte count, XOR accumulator and timer are cleared.
  - Reset mid-operation aborts the transaction. No done pulse is produced. Bytes that arrive afterwards are ignored.
- States: IDLE, SEND, WAIT_TX, RECV, CHECK, RETRY, DONE.
- IDLE:
  - start=1 latches the address and clears the retry count, then goes to SEND.
  - start in any other state is ignored.
  - rx_dv in IDLE is discarded.
- SEND: tx_dv=1 for exactly one cycle with tx_byte=address, then WAIT_TX. Latency: start at cycle N gives tx_dv at cycle N+1.
- WAIT_TX:
  - Timer runs.
  - tx_done goes to RECV; the timer, byte count and accumulator are cleared and the accumulator is loaded with SEED.
  - Timer expiry goes to RETRY or timeout completion, the same as in RECV.
- RECV:
  - Each rx_dv increments the byte count.
  - Data bytes shift into the data register, first byte most significant, right-aligned in [8*DATA_BYTES-1:0].
  - Each data byte is XORed into the accumulator. Byte DATA_BYTES+1 is the checksum and is captured separately, then the block goes to CHECK.
  - Timer expiry with no rx_dv in that cycle: if retries used < MAX_RETRIES go to RETRY, else go to DONE with status TIMEOUT.
  - rx_dv has priority over expiry in the same cycle. If that byte completes the packet, go to CHECK.
- CHECK (1 cycle):
  - accumulator == checksum byte: DONE with status OK.
  - Otherwise: RETRY if retries are left, else DONE with status CHK_ERR.
- RETRY (1 cycle): increment the retry count, then go to SEND. Data, byte count and accumulator are cleared on re-entry to RECV.
- DONE (1 cycle):
  - done=1 and result is updated in the same cycle, then IDLE.
  - result holds its value until the next DONE or reset.
  - Status codes: 00 OK, 01 TIMEOUT, 10 CHK_ERR. On a non-OK status the data field holds whatever was received in the last attempt.
- Timer: the expired flag asserts when the count reaches TIMEOUT_CYCLES-1. The timer saturates and does not wrap.
- Width rule: CNT_W = clog2(TIMEOUT_CYCLES). Unused data bits are zero.

Decomposition:
- Shared package (sensor_pkg):
  - state encoding
  - status codes STAT_OK, STAT_TIMEOUT, STAT_CHK_ERR
  - result field offsets
  - default SEED
- One sub-module, response_timer. Inputs: clock, reset, clear, enable. Output: expired. Parameter: TIMEOUT_CYCLES.

Test Plan:
- Good response (bench: TIMEOUT_CYCLES=100, MAX_RETRIES=2, DATA_BYTES=2). start with dataA=0x05. Expect tx_dv one cycle later with tx_byte=0x05. Pulse tx_done, then rx bytes 0x12, 0x34, 0x11. Expect done with result=0x00001234.
- Checksum error then good. First attempt replies 0x12, 0x34, 0x00: expect a second tx_dv with 0x05. Correct reply follows. Expect result=0x01001234.
- Silent sensor. No rx bytes. Expect 3 tx_dv strobes each about 100 cycles apart, then done with result[29:28]=01 and result[27:24]=2.
- Stray and overlapping start. rx_dv=0xAA in IDLE, and start pulsed during RECV. Expect no state change, a single transaction only and an unchanged result.
- Reset mid-RECV after one byte. Expect busy=0, no done and result=0. A new request completes normally.
- Simultaneous final byte and expiry. The last byte arrives in the expiry cycle. Expect CHECK to be taken and status OK, with no retry.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor poll arbiter: FSM encoding, status codes,
// result field layout and the default checksum seed.
package sensor_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT_TX = 3'd2,
    S_RECV    = 3'd3,
    S_CHECK   = 3'd4,
    S_RETRY   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_TIMEOUT = 2'b01;
  localparam logic [1:0] STAT_CHK_ERR = 2'b10;

  localparam int RES_DATA_LSB  = 0;
  localparam int RES_RETRY_LSB = 24;
  localparam int RES_STAT_LSB  = 28;

  localparam logic [7:0] DEFAULT_SEED = 8'h37;

  function automatic logic [31:0] pack_result(input logic [1:0] status,
                                              input logic [3:0] retries,
                                              input logic [23:0] data);
    logic [31:0] w_res;
    w_res = 32'h0;
    w_res[RES_DATA_LSB +: 24] = data;
    w_res[RES_RETRY_LSB +: 4] = retries;
    w_res[RES_STAT_LSB +: 2]  = status;
    return w_res;
  endfunction

endpackage

// File: rtl/sensor_poll_arbiter_response_timer.sv
// Per-attempt response timer: counts enabled cycles and saturates at
// TIMEOUT_CYCLES-1, where expired is raised.
module response_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable && (r_count != LAST)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign expired = (r_count == LAST);

endmodule

// File: rtl/sensor_poll_arbiter.sv
// Sensor request arbiter: sends a one-byte sensor address over UART, gathers a
// checksummed multi-byte reply with timeout and retry, and reports to the CPU.
module sensor_poll_arbiter #(
  parameter int                ADDR_W         = 8,
  parameter int                DATA_BYTES     = 2,
  parameter int unsigned       TIMEOUT_CYCLES = 500000000,
  parameter int                MAX_RETRIES    = 2,
  parameter logic [7:0]        SEED           = sensor_pkg::DEFAULT_SEED
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  output logic [7:0]  tx_byte,
  output logic        tx_dv,
  input  logic        tx_done,
  input  logic [7:0]  rx_byte,
  input  logic        rx_dv,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  import sensor_pkg::*;

  localparam logic [23:0] DATA_MASK = 24'((33'h1 << (8 * DATA_BYTES)) - 33'h1);

  state_t      r_state, w_next;
  logic [1:0]  w_status;
  logic        w_timer_clear, w_timer_en, w_expired, w_retry_left;
  logic [7:0]  r_tx_byte, r_acc, r_chk;
  logic        r_tx_dv, r_done, r_busy;
  logic [3:0]  r_retry;
  logic [2:0]  r_cnt;
  logic [23:0] r_data;
  logic [31:0] r_result;
  logic        w_unused_dataA;

  assign w_unused_dataA = &{1'b0, dataA};
  assign w_retry_left   = (r_retry < 4'(MAX_RETRIES));

  response_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_timer_clear),
    .enable  (w_timer_en),
    .expired (w_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_status      = STAT_OK;
    w_timer_clear = 1'b0;
    w_timer_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_clear = 1'b1;
        if (start) w_next = S_SEND;
        else       w_next = S_IDLE;
      end
      S_SEND: begin
        w_timer_clear = 1'b1;
        w_next        = S_WAIT_TX;
      end
      S_WAIT_TX, S_RECV: begin
        w_timer_en = 1'b1;
        // An incoming byte (or tx completion) wins over expiry in the same cycle.
        if ((r_state == S_WAIT_TX) && tx_done) begin
          w_timer_clear = 1'b1;
          w_next        = S_RECV;
        end else if ((r_state == S_RECV) && rx_dv) begin
          if (r_cnt == 3'(DATA_BYTES)) w_next = S_CHECK;
          else                         w_next = S_RECV;
        end else if (w_expired) begin
          if (w_retry_left) begin
            w_next = S_RETRY;
          end else begin
            w_next   = S_DONE;
            w_status = STAT_TIMEOUT;
          end
        end else begin
          w_next = r_state;
        end
      end
      S_CHECK: begin
        if (r_acc == r_chk) begin
          w_next = S_DONE;
        end else if (w_retry_left) begin
          w_next = S_RETRY;
        end else begin
          w_next   = S_DONE;
          w_status = STAT_CHK_ERR;
        end
      end
      S_RETRY: w_next = S_SEND;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_byte <= 8'h00;
      r_tx_dv   <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_retry   <= 4'd0;
      r_cnt     <= 3'd0;
      r_acc     <= 8'h00;
      r_chk     <= 8'h00;
      r_data    <= 24'h0;
      r_result  <= 32'h0;
    end else begin
      r_tx_dv <= (w_next == S_SEND);
      r_done  <= (w_next == S_DONE);
      r_busy  <= (w_next != S_IDLE);
      if ((r_state == S_IDLE) && start) begin
        r_tx_byte <= 8'(dataA[ADDR_W-1:0]);
        r_retry   <= 4'd0;
      end
      if (r_state == S_RETRY) r_retry <= r_retry + 4'd1;
      if ((r_state == S_WAIT_TX) && tx_done) begin
        r_cnt  <= 3'd0;
        r_acc  <= SEED;
        r_data <= 24'h0;
      end
      if ((r_state == S_RECV) && rx_dv) begin
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt < 3'(DATA_BYTES)) begin
          r_data <= {r_data[15:0], rx_byte} & DATA_MASK;
          r_acc  <= r_acc ^ rx_byte;
        end else begin
          r_chk <= rx_byte;
        end
      end
      // Result is loaded on entry to DONE so it is valid alongside the done pulse.
      if ((w_next == S_DONE) && (r_state != S_DONE))
        r_result <= pack_result(w_status, r_retry, r_data);
    end
  end

  assign tx_byte = r_tx_byte;
  assign tx_dv   = r_tx_dv;
  assign done    = r_done;
  assign busy    = r_busy;
  assign result  = r_result;

endmodule

// File: tb/tb_sensor_poll_arbiter.sv
// Directed scoreboard bench for sensor_poll_arbiter (TIMEOUT_CYCLES=100,
// MAX_RETRIES=2, DATA_BYTES=2).
module tb_sensor_poll_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataA = 32'h0;
  logic [7:0]  tx_byte;
  logic        tx_dv;
  logic        tx_done = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_dv = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;
  int tx_count = 0;
  int done_count = 0;
  longint tx_times[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_res[$];

  sensor_poll_arbiter #(
    .ADDR_W(8), .DATA_BYTES(2), .TIMEOUT_CYCLES(100), .MAX_RETRIES(2), .SEED(8'h37)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .dataA(dataA),
    .tx_byte(tx_byte), .tx_dv(tx_dv), .tx_done(tx_done),
    .rx_byte(rx_byte), .rx_dv(rx_dv), .busy(busy), .done(done), .result(result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clock) begin
    if (tx_dv) begin
      tx_count++;
      tx_times.push_back($time);
      check("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
      if (exp_tx.size() != 0) check("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
    end
    if (done) begin
      done_count++;
      check("done_expected", 32'(exp_res.size() != 0), 32'd1);
      if (exp_res.size() != 0) check("result", result, exp_res.pop_front());
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_start(input logic [31:0] a);
    dataA = a; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    step(1);
    tx_done = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_byte = b; rx_dv = 1'b1;
    step(1);
    rx_dv = 1'b0;
  endtask

  task automatic wait_tx(input int budget);
    int base = tx_count;
    int i = 0;
    while (tx_count == base && i < budget) begin
      step(1);
      i++;
    end
    check("tx_wait", tx_count, base + 1);
  endtask

  task automatic wait_done(input int budget);
    int base = done_count;
    int i = 0;
    while (done_count == base && i < budget) begin
      step(1);
      i++;
    end
    check("done_wait", done_count, base + 1);
  endtask

  initial begin
    int tx_base;
    int done_base;
    step(3);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tx_dv", 32'(tx_dv), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_result", result, 32'd0);
    step(2);

    // 1: good response, checks one-cycle start-to-tx_dv latency
    exp_tx.push_back(8'h05);
    exp_res.push_back(32'h0000_1234);
    do_start(32'hFFFF_FF05);
    check("latency_tx_dv", 32'(tx_dv), 32'd1);
    check("latency_busy", 32'(busy), 32'd1);
    step(1);
    check("tx_dv_one_cycle", 32'(tx_dv), 32'd0);
    step(1);
    pulse_tx_done();
    send_rx(8'h12); send_rx(8'h34); send_rx(8'h11);
    wait_done(20);
    step(1);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("result_hold", result, 32'h0000_1234);

    // 2: checksum error then good
    exp_tx.push_back(8'h05); exp_tx.push_back(8'h05);
    exp_res.push_back(32'h0100_1234);
    do_start(32'h0000_0005);
    wait_tx(10);
    pulse_tx_done();
    send_rx(8'h12); send_rx(8'h34); send_rx(8'h00);
    wait_tx(20);
    pulse_tx_done();
    send_rx(8'h12); send_rx(8'h34); send_rx(8'h11);
    wait_done(20);
    step(2);

    // 3: silent sensor, three attempts 103 cycles apart, timeout status
    tx_times.delete();
    for (int k = 0; k < 3; k++) exp_tx.push_back(8'h05);
    exp_res.push_back(32'h1200_0000);
    do_start(32'h0000_0005);
    for (int k = 0; k < 3; k++) begin
      wait_tx(300);
      pulse_tx_done();
    end
    wait_done(300);
    check("silent_attempts", 32'(tx_times.size()), 32'd3);
    if (tx_times.size() == 3) begin
      check("silent_gap1", 32'((tx_times[1] - tx_times[0]) / 10), 32'd103);
      check("silent_gap2", 32'((tx_times[2] - tx_times[1]) / 10), 32'd103);
    end
    step(2);

    // 4: stray rx in IDLE and overlapping start in RECV
    send_rx(8'hAA);
    step(1);
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_result", result, 32'h1200_0000);
    tx_base = tx_count; done_base = done_count;
    exp_tx.push_back(8'h3C);
    exp_res.push_back(32'h0000_ABCD);
    do_start(32'h0000_003C);
    wait_tx(10);
    pulse_tx_done();
    send_rx(8'hAB);
    do_start(32'h0000_0077);
    send_rx(8'hCD); send_rx(8'h51);
    wait_done(20);
    step(10);
    check("overlap_tx_count", tx_count, tx_base + 1);
    check("overlap_done_count", done_count, done_base + 1);
    check("overlap_busy", 32'(busy), 32'd0);

    // 5: reset mid-RECV, then a clean request
    exp_tx.push_back(8'h05);
    done_base = done_count;
    do_start(32'h0000_0005);
    wait_tx(10);
    pulse_tx_done();
    send_rx(8'h12);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", result, 32'd0);
    send_rx(8'h34); send_rx(8'h11);
    step(8);
    check("mid_rst_no_done", done_count, done_base);
    check("mid_rst_idle", 32'(busy), 32'd0);
    exp_tx.push_back(8'h09);
    exp_res.push_back(32'h0000_0102);
    do_start(32'h0000_0009);
    wait_tx(10);
    pulse_tx_done();
    send_rx(8'h01); send_rx(8'h02); send_rx(8'h34);
    wait_done(20);
    step(2);

    // 6: checksum byte lands in the expiry cycle (100th RECV cycle)
    tx_base = tx_count;
    exp_tx.push_back(8'h05);
    exp_res.push_back(32'h0000_5678);
    do_start(32'h0000_0005);
    wait_tx(10);
    pulse_tx_done();
    send_rx(8'h56); send_rx(8'h78);
    step(97);
    send_rx(8'h19);
    wait_done(20);
    step(10);
    check("edge_no_retry", tx_count, tx_base + 1);
    check("edge_pending_tx", 32'(exp_tx.size()), 32'd0);
    check("edge_pending_res", 32'(exp_res.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
